// File: rtl/hicore_rob.sv
// In-order reorder buffer: allocates at the tail, completes entries by tag,
// and presents the oldest completed entry to commit.
`ifndef HiCore_PC_SIZE
`define HiCore_PC_SIZE 32
`endif
`ifndef HiCore_RFIDX_WIDTH
`define HiCore_RFIDX_WIDTH 5
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif
`ifndef HiCore_CSRIDX_WIDTH
`define HiCore_CSRIDX_WIDTH 12
`endif
`ifndef HiCore_EXCP_SIZE
`define HiCore_EXCP_SIZE 5
`endif
`ifndef HiCore_IRQ_SIZE
`define HiCore_IRQ_SIZE 3
`endif
`ifndef HiCore_WB_SIZE
`define HiCore_WB_SIZE (`HiCore_PC_SIZE + `HiCore_IRQ_SIZE + `HiCore_EXCP_SIZE)
`endif

module hicore_rob #(
  parameter int ROB_DEPTH = 8,
  parameter int ROB_TAG_W = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  output logic [ROB_TAG_W-1:0]             alloc_tag,
  input  logic [`HiCore_PC_SIZE-1:0]       alloc_pc,
  input  logic                             wb_valid,
  input  logic [ROB_TAG_W-1:0]             wb_tag,
  input  logic                             wb_rd_need,
  input  logic [`HiCore_RFIDX_WIDTH-1:0]   wb_rd_idx,
  input  logic [`HiCore_REG_SIZE-1:0]      wb_rd_data,
  input  logic                             wb_csr_need,
  input  logic [`HiCore_CSRIDX_WIDTH-1:0]  wb_csr_idx,
  input  logic [`HiCore_REG_SIZE-1:0]      wb_csr_data,
  input  logic                             wb_fence_i_op,
  input  logic                             wb_mret_op,
  input  logic [`HiCore_PC_SIZE-1:0]       wb_next_pc,
  input  logic [`HiCore_EXCP_SIZE-1:0]     wb_excp,
  input  logic [`HiCore_IRQ_SIZE-1:0]      irq_pending,
  input  logic                             rob_valid,
  output logic                             rob_ready,
  output logic                             rob_rd_need,
  output logic [`HiCore_RFIDX_WIDTH-1:0]   rob_rd_idx,
  output logic [`HiCore_REG_SIZE-1:0]      rob_rd_data,
  output logic                             rob_csr_need,
  output logic [`HiCore_CSRIDX_WIDTH-1:0]  rob_csr_idx,
  output logic [`HiCore_REG_SIZE-1:0]      rob_csr_data,
  output logic                             rob_fence_i_op,
  output logic                             rob_mret_op,
  output logic [`HiCore_PC_SIZE-1:0]       rob_next_pc,
  output logic [`HiCore_WB_SIZE-1:0]       rob_info,
  input  logic                             flush,
  output logic                             rob_empty
);

  typedef struct packed {
    logic [`HiCore_PC_SIZE-1:0]      pc;
    logic                            rd_need;
    logic [`HiCore_RFIDX_WIDTH-1:0]  rd_idx;
    logic [`HiCore_REG_SIZE-1:0]     rd_data;
    logic                            csr_need;
    logic [`HiCore_CSRIDX_WIDTH-1:0] csr_idx;
    logic [`HiCore_REG_SIZE-1:0]     csr_data;
    logic                            fence_i_op;
    logic                            mret_op;
    logic [`HiCore_PC_SIZE-1:0]      next_pc;
    logic [`HiCore_EXCP_SIZE-1:0]    excp;
  } ent_t;

  localparam logic [ROB_TAG_W:0] PTR_ONE = 1;

  logic [ROB_TAG_W:0]         head_q, head_d, tail_q, tail_d;
  logic [ROB_DEPTH-1:0]       vld_q, vld_d, done_q, done_d;
  ent_t [ROB_DEPTH-1:0]       ent_q, ent_d;

  logic [ROB_TAG_W-1:0] hidx, tidx;
  logic                 full, alloc_fire, retire;
  ent_t                 head_ent;

  assign hidx = head_q[ROB_TAG_W-1:0];
  assign tidx = tail_q[ROB_TAG_W-1:0];
  // Full/empty come from registered pointers only, so a same-cycle retire never frees a slot early.
  assign full        = (hidx == tidx) && (head_q[ROB_TAG_W] != tail_q[ROB_TAG_W]);
  assign rob_empty   = (head_q == tail_q);
  assign alloc_ready = ~full;
  assign alloc_tag   = tidx;
  assign alloc_fire  = alloc_valid & ~full;

  assign head_ent  = ent_q[hidx];
  assign rob_ready = vld_q[hidx] & done_q[hidx];
  assign retire    = rob_valid & rob_ready;

  assign rob_rd_need    = head_ent.rd_need;
  assign rob_rd_idx     = head_ent.rd_idx;
  assign rob_rd_data    = head_ent.rd_data;
  assign rob_csr_need   = head_ent.csr_need;
  assign rob_csr_idx    = head_ent.csr_idx;
  assign rob_csr_data   = head_ent.csr_data;
  assign rob_fence_i_op = head_ent.fence_i_op;
  assign rob_mret_op    = head_ent.mret_op;
  assign rob_next_pc    = head_ent.next_pc;
  // irq is sampled live; commit masks it.
  assign rob_info       = {head_ent.pc, irq_pending, head_ent.excp};

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    done_d = done_q;
    ent_d  = ent_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      vld_d  = '0;
      done_d = '0;
    end else begin
      if (retire) begin
        vld_d[hidx] = 1'b0;
        head_d      = head_q + PTR_ONE;
      end
      if (wb_valid && vld_q[wb_tag]) begin
        done_d[wb_tag]            = 1'b1;
        ent_d[wb_tag].rd_need     = wb_rd_need;
        ent_d[wb_tag].rd_idx      = wb_rd_idx;
        ent_d[wb_tag].rd_data     = wb_rd_data;
        ent_d[wb_tag].csr_need    = wb_csr_need;
        ent_d[wb_tag].csr_idx     = wb_csr_idx;
        ent_d[wb_tag].csr_data    = wb_csr_data;
        ent_d[wb_tag].fence_i_op  = wb_fence_i_op;
        ent_d[wb_tag].mret_op     = wb_mret_op;
        ent_d[wb_tag].next_pc     = wb_next_pc;
        ent_d[wb_tag].excp        = wb_excp;
      end
      if (alloc_fire) begin
        vld_d[tidx]     = 1'b1;
        done_d[tidx]    = 1'b0;
        ent_d[tidx].pc  = alloc_pc;
        tail_d          = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      done_q <= '0;
      ent_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
      done_q <= done_d;
      ent_q  <= ent_d;
    end
  end

endmodule

// File: tb/tb_hicore_rob.sv
// Directed bench for hicore_rob: reset, fill, out-of-order completion,
// pointer wrap, full+retire collision and flush.
`ifndef HiCore_PC_SIZE
`define HiCore_PC_SIZE 32
`endif
`ifndef HiCore_RFIDX_WIDTH
`define HiCore_RFIDX_WIDTH 5
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif
`ifndef HiCore_CSRIDX_WIDTH
`define HiCore_CSRIDX_WIDTH 12
`endif
`ifndef HiCore_EXCP_SIZE
`define HiCore_EXCP_SIZE 5
`endif
`ifndef HiCore_IRQ_SIZE
`define HiCore_IRQ_SIZE 3
`endif
`ifndef HiCore_WB_SIZE
`define HiCore_WB_SIZE (`HiCore_PC_SIZE + `HiCore_IRQ_SIZE + `HiCore_EXCP_SIZE)
`endif

module tb_hicore_rob;
  localparam int D  = 8;
  localparam int TW = 3;

  logic clk = 1'b0, rst_n;
  logic alloc_valid, alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic [`HiCore_PC_SIZE-1:0] alloc_pc;
  logic wb_valid;
  logic [TW-1:0] wb_tag;
  logic wb_rd_need, wb_csr_need, wb_fence_i_op, wb_mret_op;
  logic [`HiCore_RFIDX_WIDTH-1:0] wb_rd_idx;
  logic [`HiCore_REG_SIZE-1:0] wb_rd_data, wb_csr_data;
  logic [`HiCore_CSRIDX_WIDTH-1:0] wb_csr_idx;
  logic [`HiCore_PC_SIZE-1:0] wb_next_pc;
  logic [`HiCore_EXCP_SIZE-1:0] wb_excp;
  logic [`HiCore_IRQ_SIZE-1:0] irq_pending;
  logic rob_valid, rob_ready;
  logic rob_rd_need, rob_csr_need, rob_fence_i_op, rob_mret_op;
  logic [`HiCore_RFIDX_WIDTH-1:0] rob_rd_idx;
  logic [`HiCore_REG_SIZE-1:0] rob_rd_data, rob_csr_data;
  logic [`HiCore_CSRIDX_WIDTH-1:0] rob_csr_idx;
  logic [`HiCore_PC_SIZE-1:0] rob_next_pc;
  logic [`HiCore_WB_SIZE-1:0] rob_info;
  logic flush, rob_empty;

  int n_run  = 0;
  int n_fail = 0;

  hicore_rob #(.ROB_DEPTH(D), .ROB_TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag), .alloc_pc(alloc_pc),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_rd_need(wb_rd_need), .wb_rd_idx(wb_rd_idx), .wb_rd_data(wb_rd_data),
    .wb_csr_need(wb_csr_need), .wb_csr_idx(wb_csr_idx), .wb_csr_data(wb_csr_data),
    .wb_fence_i_op(wb_fence_i_op), .wb_mret_op(wb_mret_op), .wb_next_pc(wb_next_pc),
    .wb_excp(wb_excp), .irq_pending(irq_pending),
    .rob_valid(rob_valid), .rob_ready(rob_ready),
    .rob_rd_need(rob_rd_need), .rob_rd_idx(rob_rd_idx), .rob_rd_data(rob_rd_data),
    .rob_csr_need(rob_csr_need), .rob_csr_idx(rob_csr_idx), .rob_csr_data(rob_csr_data),
    .rob_fence_i_op(rob_fence_i_op), .rob_mret_op(rob_mret_op), .rob_next_pc(rob_next_pc),
    .rob_info(rob_info), .flush(flush), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  // Upstream must never write back an entry that is already complete.
  always @(posedge clk)
    if (rst_n && wb_valid && !flush)
      assert (!(dut.vld_q[wb_tag] && dut.done_q[wb_tag]))
        else $error("illegal writeback to completed tag %0d", wb_tag);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_pc = '0; wb_valid = 0; wb_tag = '0;
    wb_rd_need = 0; wb_rd_idx = '0; wb_rd_data = '0;
    wb_csr_need = 0; wb_csr_idx = '0; wb_csr_data = '0;
    wb_fence_i_op = 0; wb_mret_op = 0; wb_next_pc = '0; wb_excp = '0;
    irq_pending = '0; rob_valid = 0; flush = 0;
  endtask

  task automatic wb(input logic [TW-1:0] tg, input logic [31:0] data, input logic [4:0] ex);
    wb_valid = 1; wb_tag = tg; wb_rd_need = 1; wb_rd_idx = 5'(tg);
    wb_rd_data = data; wb_next_pc = data + 32'd4; wb_excp = ex;
  endtask

  initial begin
    logic [31:0] pc;
    logic [39:0] exp_info;
    logic [TW-1:0] tg;
    rst_n = 0;
    idle();
    #1;
    chk("reset_empty", 64'(rob_empty), 64'd1);
    chk("reset_ready", 64'(rob_ready), 64'd0);
    chk("reset_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("reset_alloc_tag", 64'(alloc_tag), 64'd0);
    #12 rst_n = 1;
    tick();

    // Fill to full, then a 9th request that must be refused
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1; alloc_pc = 32'h1000 + 32'(4*i);
      #1 chk("fill_tag", 64'(alloc_tag), 64'(i));
      tick();
    end
    alloc_pc = 32'h9999;
    #1 chk("full_alloc_ready", 64'(alloc_ready), 64'd0);
    tick();
    alloc_valid = 0;
    #1;
    chk("full_tail_held", 64'(alloc_tag), 64'd0);
    chk("full_still", 64'(alloc_ready), 64'd0);
    chk("full_not_empty", 64'(rob_empty), 64'd0);

    // Full buffer: retire and alloc collide, alloc must wait one cycle
    wb(3'd0, 32'hA0, 5'd0);
    #1 chk("wb_latency", 64'(rob_ready), 64'd0);
    tick();
    wb_valid = 0;
    #1;
    chk("head_ready", 64'(rob_ready), 64'd1);
    chk("head_data", 64'(rob_rd_data), 64'hA0);
    chk("head_pc", 64'(rob_info[39:8]), 64'h1000);
    rob_valid = 1; alloc_valid = 1; alloc_pc = 32'h2000;
    #1 chk("collide_blocked", 64'(alloc_ready), 64'd0);
    tick();
    rob_valid = 0;
    #1;
    chk("after_retire_ready", 64'(alloc_ready), 64'd1);
    chk("after_retire_tag", 64'(alloc_tag), 64'd0);
    chk("head1_not_done", 64'(rob_ready), 64'd0);
    tick();
    alloc_valid = 0;
    #1 chk("refull", 64'(alloc_ready), 64'd0);

    // Asynchronous reset with 5 live entries
    rst_n = 0; #1 rst_n = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1; alloc_pc = 32'h3000 + 32'(4*i);
      tick();
    end
    alloc_valid = 0;
    wb(3'd0, 32'h55, 5'd0);
    tick();
    wb_valid = 0;
    #1 chk("pre_reset_ready", 64'(rob_ready), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("async_empty", 64'(rob_empty), 64'd1);
    chk("async_ready", 64'(rob_ready), 64'd0);
    chk("async_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("async_alloc_tag", 64'(alloc_tag), 64'd0);
    #1 rst_n = 1;
    tick();

    // Out-of-order completion, in-order retire
    rob_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_pc = 32'h4000 + 32'(4*i);
      #1 chk("ooo_tag", 64'(alloc_tag), 64'(i));
      tick();
    end
    alloc_valid = 0;
    wb(3'd2, 32'h22, 5'd0);
    #1 chk("ooo_wait2", 64'(rob_ready), 64'd0);
    tick();
    wb(3'd1, 32'h11, 5'd0);
    #1 chk("ooo_wait1", 64'(rob_ready), 64'd0);
    tick();
    wb(3'd0, 32'h00, 5'd0);
    #1 chk("ooo_wait0", 64'(rob_ready), 64'd0);
    tick();
    wb_valid = 0;
    #1;
    chk("ooo_r0_ready", 64'(rob_ready), 64'd1);
    chk("ooo_r0_data", 64'(rob_rd_data), 64'h00);
    tick();
    chk("ooo_r1_ready", 64'(rob_ready), 64'd1);
    chk("ooo_r1_data", 64'(rob_rd_data), 64'h11);
    tick();
    chk("ooo_r2_ready", 64'(rob_ready), 64'd1);
    chk("ooo_r2_data", 64'(rob_rd_data), 64'h22);
    tick();
    chk("ooo_done_ready", 64'(rob_ready), 64'd0);
    chk("ooo_done_empty", 64'(rob_empty), 64'd1);
    rob_valid = 0;

    // Wrap: tail starts at 3, 20 round trips cross the wrap boundary
    for (int i = 0; i < 20; i++) begin
      tg = 3'((3 + i) % 8);
      pc = 32'h8000_0000 + 32'(4*i);
      alloc_valid = 1; alloc_pc = pc; irq_pending = 3'(i);
      #1 chk("wrap_tag", 64'(alloc_tag), 64'(tg));
      tick();
      alloc_valid = 0;
      wb(tg, 32'(i), 5'(i));
      #1 chk("wrap_wb_latency", 64'(rob_ready), 64'd0);
      tick();
      wb_valid = 0;
      exp_info = {pc, 3'(i), 5'(i)};
      #1 chk("wrap_info", 64'(rob_info), 64'(exp_info));
      rob_valid = 1;
      tick();
      rob_valid = 0;
    end
    #1 chk("wrap_empty", 64'(rob_empty), 64'd1);
    irq_pending = '0;

    // Flush with 6 live entries (tags 7,0,1,2,3,4), colliding with retire and wb
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1; alloc_pc = 32'h5000 + 32'(4*i);
      tick();
    end
    alloc_valid = 0;
    wb(3'd7, 32'h77, 5'd0);
    tick();
    wb_valid = 0;
    #1 chk("flush_pre_ready", 64'(rob_ready), 64'd1);
    rob_valid = 1; flush = 1;
    wb(3'd3, 32'h33, 5'd0);
    tick();
    idle();
    #1;
    chk("flush_empty", 64'(rob_empty), 64'd1);
    chk("flush_ready", 64'(rob_ready), 64'd0);
    chk("flush_tag", 64'(alloc_tag), 64'd0);
    chk("flush_alloc_ready", 64'(alloc_ready), 64'd1);
    wb(3'd3, 32'h33, 5'd0);
    tick();
    wb_valid = 0;
    #1;
    chk("stale_wb_empty", 64'(rob_empty), 64'd1);
    chk("stale_wb_ready", 64'(rob_ready), 64'd0);
    alloc_valid = 1; alloc_pc = 32'h6000;
    tick();
    alloc_valid = 0;
    #1;
    chk("post_flush_head_pc", 64'(rob_info[39:8]), 64'h6000);
    chk("post_flush_not_done", 64'(rob_ready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
